voice_alloc: RTL

Polyphonic voice allocator between the UART receiver and the sound/light back-end. It decodes received note-on/note-off bytes and assigns each sounding note to one of `C_VOICES` voice slots. When all slots are busy it steals the oldest voice, and it releases any voice held longer than `C_HOLD_MS`. It runs beside `control` on the system clock and presents per-voice note/active vectors for the tone generators and `light`.

---
 rtl/voice_pkg.sv | 20 ++
 rtl/voice_alloc_ms_tick.sv | 25 ++
 rtl/voice_alloc.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/voice_pkg.sv
// Shared types and constants for the polyphonic voice allocator.
// Message layout: bit 7 selects note-on/off, bits 6:0 carry the note code.
package voice_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  localparam int          C_MSG_ON_BIT = 7;
  localparam int          C_NOTE_W     = 7;
  localparam logic [7:0]  C_ALL_OFF    = 8'h7F;

  // Age counters must be able to hold the saturation value itself.
  function automatic int age_width(input int hold_ms);
    return $clog2(hold_ms + 1);
  endfunction

endpackage

// File: rtl/voice_alloc_ms_tick.sv
// Millisecond strobe generator: one-cycle tick every C_CLK_FRQ/1000 clocks.
// The counter restarts from 0 on reset, so the first tick lands a full period after release.
module ms_tick #(
  parameter int C_CLK_FRQ = 100_000_000
) (
  input  logic clk,
  input  logic rstb,
  output logic tick
);

  localparam int C_DIV   = C_CLK_FRQ / 1000;
  localparam int C_CNT_W = $clog2(C_DIV + 1);
  localparam logic [C_CNT_W-1:0] C_TC = C_CNT_W'(C_DIV - 1);

  logic [C_CNT_W-1:0] cnt;

  assign tick = (cnt == C_TC);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: decodes note-on/off bytes, scans the voice slots one per
// cycle, then commits an assign, retrigger, steal, release or all-off; voices time out.
//   state     | meaning
//   ST_IDLE   | waiting for a byte (held byte first), capture it
//   ST_SCAN   | examine one voice per cycle: first match, lowest free, oldest active
//   ST_COMMIT | apply the decision to the voice arrays, pulse steal if overwriting
module voice_alloc
  import voice_pkg::*;
#(
  parameter int C_CLK_FRQ         = 100_000_000,
  parameter int C_VOICES          = 4,
  parameter int C_HOLD_MS         = 5000,
  parameter int C_UART_DATA_WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rstb,
  input  logic                               UART_valid,
  input  logic [C_UART_DATA_WIDTH-1:0]       UART_msg,
  input  logic                               UART_err,
  output logic [C_VOICES-1:0]                voiceActive,
  output logic [C_NOTE_W*C_VOICES-1:0]       voiceNote,
  output logic                               busy,
  output logic                               steal,
  output logic                               drop
);

  localparam int C_AGE_W = age_width(C_HOLD_MS);
  localparam int C_IDX_W = $clog2(C_VOICES);
  localparam logic [C_AGE_W-1:0] C_AGE_MAX  = C_AGE_W'(C_HOLD_MS);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_VOICES - 1);

  state_t               state;
  logic [7:0]           msg_q;
  logic [7:0]           hold_msg;
  logic                 hold_full;
  logic [C_IDX_W-1:0]   scan_idx;
  logic [C_IDX_W-1:0]   match_idx;
  logic [C_IDX_W-1:0]   free_idx;
  logic [C_IDX_W-1:0]   old_idx;
  logic [C_IDX_W-1:0]   target_idx;
  logic                 match_found;
  logic                 free_found;
  logic                 old_found;
  logic [C_AGE_W-1:0]   old_age;
  logic [C_VOICES-1:0]  active_q;
  logic [C_NOTE_W-1:0]  note_q [C_VOICES];
  logic [C_AGE_W-1:0]   age_q  [C_VOICES];

  logic                 tick;
  logic                 in_valid;
  logic                 start;
  logic [7:0]           start_msg;
  logic                 is_all_off;
  logic                 is_on;
  logic [C_NOTE_W-1:0]  msg_note;

  ms_tick #(.C_CLK_FRQ(C_CLK_FRQ)) u_ms_tick (
    .clk  (clk),
    .rstb (rstb),
    .tick (tick)
  );

  assign in_valid   = UART_valid & ~UART_err;
  assign start_msg  = hold_full ? hold_msg : UART_msg;
  assign start      = (state == ST_IDLE) && (hold_full || in_valid);
  assign is_all_off = (msg_q == C_ALL_OFF);
  assign is_on      = msg_q[C_MSG_ON_BIT];
  assign msg_note   = msg_q[C_NOTE_W-1:0];
  assign target_idx = match_found ? match_idx : (free_found ? free_idx : old_idx);

  assign busy        = (state != ST_IDLE);
  assign steal       = (state == ST_COMMIT) && !is_all_off && is_on && !match_found && !free_found;
  assign voiceActive = active_q;

  always_comb begin
    voiceNote = '0;
    for (int v = 0; v < C_VOICES; v++) voiceNote[v*C_NOTE_W +: C_NOTE_W] = note_q[v];
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state       <= ST_IDLE;
      msg_q       <= '0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          msg_q       <= start_msg;
          scan_idx    <= '0;
          match_found <= 1'b0;
          free_found  <= 1'b0;
          old_found   <= 1'b0;
          old_age     <= '0;
          state       <= (start_msg == C_ALL_OFF) ? ST_COMMIT : ST_SCAN;
        end
        ST_SCAN: begin
          if (active_q[scan_idx]) begin
            if (!match_found && note_q[scan_idx] == msg_note) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            // strict compare keeps the lowest index on equal ages
            if (!old_found || age_q[scan_idx] > old_age) begin
              old_found <= 1'b1;
              old_idx   <= scan_idx;
              old_age   <= age_q[scan_idx];
            end
          end else if (!free_found) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (scan_idx == C_LAST_IDX) state <= ST_COMMIT;
          else                        scan_idx <= scan_idx + 1'b1;
        end
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      hold_full <= 1'b0;
      hold_msg  <= '0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (state == ST_IDLE) begin
        // the held byte is being consumed; a fresh byte may refill the slot
        if (hold_full) begin
          if (in_valid) hold_msg  <= UART_msg;
          else          hold_full <= 1'b0;
        end
      end else if (in_valid) begin
        if (!hold_full) begin
          hold_full <= 1'b1;
          hold_msg  <= UART_msg;
        end else begin
          drop <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      active_q <= '0;
      for (int v = 0; v < C_VOICES; v++) begin
        note_q[v] <= '0;
        age_q[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < C_VOICES; v++) begin
        if (tick && active_q[v]) begin
          if (age_q[v] < C_AGE_MAX)           age_q[v]    <= age_q[v] + 1'b1;
          if (age_q[v] >= C_AGE_MAX - 1'b1)   active_q[v] <= 1'b0;
        end
      end
      // placed after the timeout update so a commit overrides a same-cycle timeout
      if (state == ST_COMMIT) begin
        if (is_all_off) begin
          active_q <= '0;
        end else if (is_on) begin
          active_q[target_idx] <= 1'b1;
          note_q[target_idx]   <= msg_note;
          age_q[target_idx]    <= '0;
        end else if (match_found) begin
          active_q[match_idx] <= 1'b0;
        end
      end
    end
  end

endmodule
